reset_sequencer_multi: RTL and testbench

Parametrised multi-domain reset sequencer for the PolarFire fabric. It takes one aggregated, qualified reset, INTERNAL_RST, and produces NUM_CH fabric reset outputs. Each output is released after its own programmable stretch count, in strict channel order: channel k releases only after channel k-1 is released and has been stable for GAP_CYCLES. It sits between the device-status qualification logic and the fabric clock domains (CPU, Kyber accelerator, peripherals).

---
 rtl/reset_sequencer_multi.sv | 206 ++++++++++++++++++++
 tb/tb_reset_sequencer_multi.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/reset_sequencer_multi.sv
// Multi-channel reset sequencer: releases NUM_CH fabric resets in channel order with per-channel stretch.
// Optional HOLD watchdog (WDOG_TRIP port) is built when RESET_SEQ_WATCHDOG_EN is defined.
module reset_sequencer_multi #(
  parameter int unsigned                  NUM_CH       = 4,
  parameter int unsigned                  CNT_W        = 8,
  parameter logic [NUM_CH*CNT_W-1:0]      STRETCH_INIT = {NUM_CH{CNT_W'(16)}},
  parameter int unsigned                  GAP_CYCLES   = 4,
  parameter int unsigned                  SYNC_STAGES  = 2
) (
  input  logic              CLK,
  input  logic              INTERNAL_RST,
  input  logic              FF_US_RESTORE,
  input  logic [NUM_CH-1:0] REQ_RST_N,
  input  logic              CFG_WE,
  input  logic [2:0]        CFG_CH,
  input  logic [CNT_W-1:0]  CFG_VAL,
  output logic [NUM_CH-1:0] RESET_N,
  output logic              SEQ_DONE,
  output logic              BUSY
`ifdef RESET_SEQ_WATCHDOG_EN
  ,
  output logic              WDOG_TRIP
`endif
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_GAP, S_HOLD, S_DONE} state_t;

  state_t             r_state;
  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic [NUM_CH-1:0]  r_req_sync [SYNC_STAGES];
  logic [NUM_CH-1:0]  w_req_s, w_req_act, w_clr_mask, w_ge_mask, w_set_mask, r_reset_n;
  logic [CNT_W-1:0]   r_stretch [NUM_CH];
  logic [CNT_W-1:0]   r_cnt, w_ld_val;
  logic [GAP_W-1:0]   r_gap;
  logic [IDX_W-1:0]   r_ch_idx, w_req_k, w_ld_idx;
  logic               w_req_any, w_acc, w_abort, w_hold_lower, w_hold_blk, w_release;

  // Master reset: asynchronous assert, synchronised release
  always_ff @(posedge CLK or negedge INTERNAL_RST) begin
    if (!INTERNAL_RST) r_rst_sync <= '0;
    else               r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_req_sync[i] <= '1;
    end else begin
      r_req_sync[0] <= REQ_RST_N;
      for (int i = 1; i < SYNC_STAGES; i++) r_req_sync[i] <= r_req_sync[i-1];
    end
  end
  assign w_req_s = r_req_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) r_stretch[i] <= STRETCH_INIT[i*CNT_W +: CNT_W];
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        if (CFG_WE && (CFG_CH == IDX_W'(i))) r_stretch[i] <= CFG_VAL;
    end
  end

`ifdef RESET_SEQ_WATCHDOG_EN
  logic [15:0]       r_wd_cnt;
  logic              r_wdog_trip;
  logic [NUM_CH-1:0] r_wd_ign;
  logic              w_wd_fire;

  // Inputs still low at a trip are ignored until they return high
  assign w_wd_fire = (r_state == S_HOLD) && (r_wd_cnt == 16'hFFFF) && !w_hold_lower;
  assign w_req_act = ~w_req_s & ~r_wd_ign;

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wd_cnt    <= '0;
      r_wdog_trip <= 1'b0;
      r_wd_ign    <= '0;
    end else begin
      if (r_state != S_HOLD || w_wd_fire) r_wd_cnt <= '0;
      else if (r_wd_cnt != 16'hFFFF)      r_wd_cnt <= r_wd_cnt + 16'd1;
      if (w_wd_fire) begin
        r_wdog_trip <= 1'b1;
        r_wd_ign    <= ~w_req_s & w_ge_mask;
      end else begin
        r_wd_ign    <= r_wd_ign & ~w_req_s;
      end
    end
  end
  assign WDOG_TRIP = r_wdog_trip;
`else
  assign w_req_act = ~w_req_s;
`endif

  // Lowest requesting channel, the channels it pulls into reset, and stretch lookup
  always_comb begin
    w_req_any  = 1'b0;
    w_req_k    = '0;
    w_clr_mask = '0;
    w_ge_mask  = '0;
    w_acc      = 1'b0;
    w_ld_val   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_req_act[i]) begin
        w_req_any = 1'b1;
        w_req_k   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      w_acc         = w_acc | w_req_act[i];
      w_clr_mask[i] = w_acc;
      w_ge_mask[i]  = (IDX_W'(i) >= r_ch_idx);
    end
    if (r_state == S_IDLE)      w_ld_idx = '0;
    else if (r_state == S_HOLD) w_ld_idx = r_ch_idx;
    else                        w_ld_idx = r_ch_idx + IDX_W'(1);
    for (int i = 0; i < NUM_CH; i++)
      if (w_ld_idx == IDX_W'(i)) w_ld_val = r_stretch[i];
    w_hold_lower = w_req_any && (w_req_k < r_ch_idx);
    w_hold_blk   = |(w_req_act & w_ge_mask);
    w_abort      = w_req_any && (w_req_k <= r_ch_idx) &&
                   (r_state inside {S_COUNT, S_GAP, S_DONE});
    w_release    = (r_state == S_COUNT) && (r_cnt == '0) && !w_abort;
    w_set_mask   = w_release ? (NUM_CH'(1) << r_ch_idx) : '0;
  end

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= S_IDLE;
      r_ch_idx  <= '0;
      r_cnt     <= '0;
      r_gap     <= '0;
      r_reset_n <= '0;
    end else begin
      r_reset_n <= (r_reset_n | w_set_mask) & ~w_clr_mask;
      unique case (r_state)
        S_IDLE: begin
          r_state  <= S_COUNT;
          r_ch_idx <= '0;
          r_cnt    <= w_ld_val;
        end
        S_COUNT: begin
          if (w_abort) begin
            r_state  <= S_HOLD;
            r_ch_idx <= w_req_k;
          end else if (r_cnt == '0) begin
            if (r_ch_idx == LAST_CH) begin
              r_state <= S_DONE;
            end else if (GAP_CYCLES == 0) begin
              r_ch_idx <= w_ld_idx;
              r_cnt    <= w_ld_val;
            end else begin
              r_state <= S_GAP;
              r_gap   <= GAP_W'(GAP_CYCLES - 1);
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (w_abort) begin
            r_state  <= S_HOLD;
            r_ch_idx <= w_req_k;
          end else if (r_gap == '0) begin
            r_state  <= S_COUNT;
            r_ch_idx <= w_ld_idx;
            r_cnt    <= w_ld_val;
          end else begin
            r_gap <= r_gap - GAP_W'(1);
          end
        end
        S_HOLD: begin
          if (w_hold_lower) begin
            r_ch_idx <= w_req_k;
`ifdef RESET_SEQ_WATCHDOG_EN
          end else if (w_wd_fire) begin
            r_state <= S_COUNT;
            r_cnt   <= w_ld_val;
`endif
          end else if (!w_hold_blk) begin
            r_state <= S_COUNT;
            r_cnt   <= w_ld_val;
          end
        end
        S_DONE: begin
          if (w_abort) begin
            r_state  <= S_HOLD;
            r_ch_idx <= w_req_k;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Flash*Freeze restore overrides the outputs only; sequencing state is kept
  assign RESET_N  = r_reset_n | {NUM_CH{FF_US_RESTORE}};
  assign SEQ_DONE = &r_reset_n;
  assign BUSY     = (r_state != S_DONE);

endmodule

// File: tb/tb_reset_sequencer_multi.sv
// Directed bench for reset_sequencer_multi (default parameters: 4 channels, stretch 16, gap 4).
module tb_reset_sequencer_multi;

  logic       CLK = 1'b0;
  logic       INTERNAL_RST;
  logic       FF_US_RESTORE;
  logic [3:0] REQ_RST_N;
  logic       CFG_WE;
  logic [2:0] CFG_CH;
  logic [7:0] CFG_VAL;
  logic [3:0] RESET_N;
  logic       SEQ_DONE;
  logic       BUSY;

  int   checks = 0;
  int   errors = 0;
  int   n;
  logic ch0_watch = 1'b0;
  logic ch0_dropped = 1'b0;

  reset_sequencer_multi dut (
    .CLK           (CLK),
    .INTERNAL_RST  (INTERNAL_RST),
    .FF_US_RESTORE (FF_US_RESTORE),
    .REQ_RST_N     (REQ_RST_N),
    .CFG_WE        (CFG_WE),
    .CFG_CH        (CFG_CH),
    .CFG_VAL       (CFG_VAL),
    .RESET_N       (RESET_N),
    .SEQ_DONE      (SEQ_DONE),
    .BUSY          (BUSY)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (ch0_watch && RESET_N[0] !== 1'b1) ch0_dropped <= 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts rising edges until RESET_N reaches the given value (bounded)
  task automatic wait_for(input logic [3:0] exp, output int cyc);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
    end while (RESET_N !== exp && cyc < 200);
  endtask

  initial begin
    INTERNAL_RST  = 1'b0;
    FF_US_RESTORE = 1'b0;
    REQ_RST_N     = 4'hF;
    CFG_WE        = 1'b0;
    CFG_CH        = 3'd0;
    CFG_VAL       = 8'd0;
    repeat (3) @(negedge CLK);
    chk("rst_reset_n", 32'(RESET_N), 32'h0);
    chk("rst_seq_done", 32'(SEQ_DONE), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h1);

    // Power-up sequence: ch0 at edge 20, then every 17+4 edges
    INTERNAL_RST = 1'b1;
    wait_for(4'b0001, n); chk("seq_ch0_lat", 32'(n), 32'd20);
    chk("seq_mid_done", 32'(SEQ_DONE), 32'h0);
    chk("seq_mid_busy", 32'(BUSY), 32'h1);
    wait_for(4'b0011, n); chk("seq_ch1_lat", 32'(n), 32'd21);
    wait_for(4'b0111, n); chk("seq_ch2_lat", 32'(n), 32'd21);
    wait_for(4'b1111, n); chk("seq_ch3_lat", 32'(n), 32'd21);
    chk("seq_done", 32'(SEQ_DONE), 32'h1);
    chk("seq_busy", 32'(BUSY), 32'h0);

    // Stretch writes: ch2 -> 0, out-of-range channel 5 ignored
    CFG_WE = 1'b1; CFG_CH = 3'd2; CFG_VAL = 8'd0;
    @(negedge CLK);
    CFG_CH = 3'd5;
    @(negedge CLK);
    CFG_WE = 1'b0;

    // Soft request on ch1 for 3 cycles
    REQ_RST_N = 4'b1101;
    ch0_watch = 1'b1;
    repeat (2) @(negedge CLK);
    chk("req_sync_delay", 32'(RESET_N), 32'hF);
    @(negedge CLK);
    chk("req_hold_mask", 32'(RESET_N), 32'h1);
    chk("req_hold_done", 32'(SEQ_DONE), 32'h0);
    chk("req_hold_busy", 32'(BUSY), 32'h1);
    REQ_RST_N = 4'hF;
    wait_for(4'b0011, n); chk("req_ch1_lat", 32'(n), 32'd20);
    wait_for(4'b0111, n); chk("req_ch2_zero_stretch", 32'(n), 32'd5);
    wait_for(4'b1111, n); chk("req_ch3_lat", 32'(n), 32'd21);
    ch0_watch = 1'b0;
    @(negedge CLK);
    chk("req_ch0_kept", 32'(ch0_dropped), 32'h0);
    chk("req_done_again", 32'(SEQ_DONE), 32'h1);

    // Flash*Freeze override during ch0 COUNT
    INTERNAL_RST = 1'b0;
    repeat (3) @(negedge CLK);
    INTERNAL_RST = 1'b1;
    repeat (5) @(negedge CLK);
    FF_US_RESTORE = 1'b1;
    #1;
    chk("ff_force_high", 32'(RESET_N), 32'hF);
    chk("ff_seq_done", 32'(SEQ_DONE), 32'h0);
    repeat (6) @(negedge CLK);
    FF_US_RESTORE = 1'b0;
    #1;
    chk("ff_release_low", 32'(RESET_N), 32'h0);
    wait_for(4'b0001, n); chk("ff_resume_lat", 32'(n), 32'd9);

    // Master reset while in the gap after ch1
    wait_for(4'b0011, n); chk("mid_ch1_lat", 32'(n), 32'd21);
    repeat (2) @(negedge CLK);
    INTERNAL_RST = 1'b0;
    #1;
    chk("mid_rst_async", 32'(RESET_N), 32'h0);
    chk("mid_rst_busy", 32'(BUSY), 32'h1);
    repeat (3) @(negedge CLK);
    INTERNAL_RST = 1'b1;
    wait_for(4'b0001, n); chk("mid_restart_ch0", 32'(n), 32'd20);
    wait_for(4'b0011, n); chk("mid_restart_ch1", 32'(n), 32'd21);
    wait_for(4'b0111, n); chk("mid_restart_ch2", 32'(n), 32'd21);
    wait_for(4'b1111, n); chk("mid_restart_ch3", 32'(n), 32'd21);
    chk("mid_restart_done", 32'(SEQ_DONE), 32'h1);

    // Simultaneous requests on ch2 and ch3: lowest wins
    REQ_RST_N = 4'b0011;
    repeat (3) @(negedge CLK);
    chk("simul_lowest", 32'(RESET_N), 32'h3);
    REQ_RST_N = 4'hF;
    wait_for(4'b0111, n); chk("simul_ch2_lat", 32'(n), 32'd20);
    wait_for(4'b1111, n); chk("simul_ch3_lat", 32'(n), 32'd21);
    chk("simul_busy", 32'(BUSY), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
